// File: rtl/zmips_alu_md.sv
// zmips_alu_md
//   Sequential ALU for the zmips execute stage. Single-cycle logic/arith/shift
//   ops plus iterative radix-2 multiply and restoring divide, signed or unsigned.
//   A result is held on the outputs until the consumer takes it.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
//   ready are both high. The producer keeps valid and payload stable until the
//   transfer happens. The consumer may drive ready freely. in_ready is also high
//   in DONE when out_ready is high, so a new op can be accepted in the same
//   cycle the previous result is taken.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous squash: abort the op, drop the held result
//   in_valid/in_ready operand handshake
//   op[4:0]           op[4]=0 fast op (op[3] group, op[2:1] select, op[0] invert b)
//                     op[4]=1 MD op in op[1:0]: 00 MULU 01 MUL 10 DIVU 11 DIV
//   a, b, shamt, cin  operands (a = dividend / multiplicand)
//   out_valid/out_ready result handshake
//   y, hi             result low / product high or remainder
//   zero, cout, dz    ~|y, carry or last shifted-out bit, divide-by-zero
//   o_dbg_state       FSM state (0 IDLE, 1 CALC, 2 DONE)
module zmips_alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             cout,
  output logic             dz,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_nxt_state;

  // iteration registers: r_hi is one bit wider to hold the adder carry /
  // the trial-subtract sign; r_lo is multiplier or dividend/quotient
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_d;
  logic [SHW-1:0]   r_cnt;
  logic             r_div;
  logic             r_sa;
  logic             r_sb;

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_hi_out;
  logic             r_cout;
  logic             r_dz;

  logic w_accept, w_go, w_is_md, w_dz_start, w_calc_last;

  assign in_ready    = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept    = in_valid & in_ready;
  assign w_go        = w_accept & ~flush;
  assign w_is_md     = op[4];
  assign w_dz_start  = op[4] & op[1] & (b == '0);
  assign w_calc_last = (r_state == S_CALC) & (r_cnt == SHW'(WIDTH - 1));

  assign out_valid   = (r_state == S_DONE);
  assign y           = r_y;
  assign hi          = r_hi_out;
  assign zero        = ~|r_y;
  assign cout        = r_cout;
  assign dz          = r_dz;
  assign o_dbg_state = r_state;

  // ---------------- fast ops ----------------
  logic [WIDTH-1:0] w_b_eff, w_fast_y;
  logic             w_fast_c;
  logic [WIDTH:0]   w_sum, w_sll, w_srl, w_sra;

  assign w_b_eff = b ^ {WIDTH{op[0]}};
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};
  // shifts carry one guard bit so the last bit shifted out falls into it;
  // with shamt==0 the guard stays 0
  assign w_sll   = {1'b0, a} << shamt;
  assign w_srl   = {a, 1'b0} >> shamt;
  assign w_sra   = $unsigned($signed({a, 1'b0}) >>> shamt);

  always_comb begin
    w_fast_y = '0;
    w_fast_c = 1'b0;
    case ({op[3], op[2:1]})
      3'b000: begin w_fast_y = w_sum[WIDTH-1:0]; w_fast_c = w_sum[WIDTH]; end
      3'b001: w_fast_y = a & w_b_eff;
      3'b010: w_fast_y = a | w_b_eff;
      3'b011: w_fast_y = a ^ w_b_eff;
      3'b100: w_fast_y = a;
      3'b101: begin w_fast_y = w_sll[WIDTH-1:0]; w_fast_c = w_sll[WIDTH]; end
      3'b110: begin w_fast_y = w_sra[WIDTH:1];   w_fast_c = w_sra[0];     end
      3'b111: begin w_fast_y = w_srl[WIDTH:1];   w_fast_c = w_srl[0];     end
      default: ;
    endcase
  end

  // ---------------- MD start: magnitudes ----------------
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  assign w_sa    = op[0] & a[WIDTH-1];
  assign w_sb    = op[0] & b[WIDTH-1];
  assign w_mag_a = w_sa ? (-a) : a;
  assign w_mag_b = w_sb ? (-b) : b;

  // ---------------- MD iteration step ----------------
  logic [WIDTH:0]   w_mul_add, w_div_sh, w_div_tr, w_nx_hi;
  logic [WIDTH-1:0] w_nx_lo;

  assign w_mul_add = r_lo[0] ? (r_hi + {1'b0, r_d}) : r_hi;
  assign w_div_sh  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_div_tr  = w_div_sh - {1'b0, r_d};

  always_comb begin
    w_nx_hi = {1'b0, w_mul_add[WIDTH:1]};
    w_nx_lo = {w_mul_add[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      if (!w_div_tr[WIDTH]) begin
        w_nx_hi = w_div_tr;
        w_nx_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_nx_hi = w_div_sh;
        w_nx_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // signs applied to the final magnitudes as the result is registered
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_md_y, w_md_hi;

  always_comb begin
    w_prod  = {w_nx_hi[WIDTH-1:0], w_nx_lo};
    w_md_y  = '0;
    w_md_hi = '0;
    if (r_div) begin
      w_md_y  = (r_sa ^ r_sb) ? (-w_nx_lo) : w_nx_lo;
      w_md_hi = r_sa ? (-w_nx_hi[WIDTH-1:0]) : w_nx_hi[WIDTH-1:0];
    end else begin
      if (r_sa ^ r_sb) w_prod = -w_prod;
      w_md_y  = w_prod[WIDTH-1:0];
      w_md_hi = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_nxt_state = (!w_is_md || w_dz_start) ? S_DONE : S_CALC;
      S_CALC: if (w_calc_last) w_nxt_state = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (w_go) w_nxt_state = (!w_is_md || w_dz_start) ? S_DONE : S_CALC;
          else      w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    if (flush) w_nxt_state = S_IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_y      <= '0;
      r_hi_out <= '0;
      r_cout   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      if (w_go && w_is_md && !w_dz_start) begin
        r_hi  <= '0;
        r_lo  <= op[1] ? w_mag_a : w_mag_b;
        r_d   <= op[1] ? w_mag_b : w_mag_a;
        r_cnt <= '0;
        r_div <= op[1];
        r_sa  <= w_sa;
        r_sb  <= w_sb;
      end else if (r_state == S_CALC) begin
        r_hi  <= w_nx_hi;
        r_lo  <= w_nx_lo;
        r_cnt <= r_cnt + SHW'(1);
      end

      if (w_go && !w_is_md) begin
        r_y      <= w_fast_y;
        r_hi_out <= '0;
        r_cout   <= w_fast_c;
        r_dz     <= 1'b0;
      end else if (w_go && w_dz_start) begin
        r_y      <= '1;
        r_hi_out <= a;
        r_cout   <= 1'b0;
        r_dz     <= 1'b1;
      end else if (w_calc_last && !flush) begin
        r_y      <= w_md_y;
        r_hi_out <= w_md_hi;
        r_cout   <= 1'b0;
        r_dz     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zmips_alu_md.sv
// Directed testbench for zmips_alu_md (WIDTH=32).
module tb_zmips_alu_md;
  localparam int W = 32;

  logic         clk, rst_n, flush, in_valid, in_ready, cin, out_valid, out_ready;
  logic [4:0]   op;
  logic [W-1:0] a, b, y, hi;
  logic [4:0]   shamt;
  logic         zero, cout, dz;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W+1:0] exp_q[$];

  zmips_alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .hi(hi), .zero(zero), .cout(cout), .dz(dz),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input logic [4:0] t_op,
                        input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                        input logic [4:0] t_sh, input logic t_cin, input int exp_lat,
                        input logic [W-1:0] e_y, input logic [W-1:0] e_hi,
                        input logic e_c, input logic e_dz);
    int lat;
    logic [2*W+1:0] e;
    exp_q.push_back({e_dz, e_c, e_hi, e_y});
    op = t_op; a = t_a; b = t_b; shamt = t_sh; cin = t_cin;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        shamt = 5'($urandom_range(0, 31)); cin = 1'($urandom_range(0, 1));
      end
    end while (!out_valid && lat < 100);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    check({tag, " y"},    64'(y),    64'(e[W-1:0]));
    check({tag, " hi"},   64'(hi),   64'(e[2*W-1:W]));
    check({tag, " zero"}, 64'(zero), 64'(e[W-1:0] == '0));
    check({tag, " cout"}, 64'(cout), 64'(e[2*W]));
    check({tag, " dz"},   64'(dz),   64'(e[2*W+1]));
    @(posedge clk); #1;
    check({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic saw;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; shamt = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready",  64'(in_ready),  64'd1);
    check("rst y",         64'(y),         64'd0);
    check("rst hi",        64'(hi),        64'd0);
    check("rst zero",      64'(zero),      64'd1);
    check("rst cout",      64'(cout),      64'd0);
    check("rst dz",        64'(dz),        64'd0);
    check("rst state",     64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fast ops
    run_op("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'h1,         5'd0, 1'b0, 1, 32'h0,         32'h0, 1'b1, 1'b0);
    run_op("sub_cin",  5'd1,  32'h5,         32'h3,         5'd0, 1'b1, 1, 32'h2,         32'h0, 1'b1, 1'b0);
    run_op("and",      5'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b0, 1, 32'h00F0_1234, 32'h0, 1'b0, 1'b0);
    run_op("or",       5'd4,  32'h0000_00F0, 32'h0000_000F, 5'd0, 1'b0, 1, 32'h0000_00FF, 32'h0, 1'b0, 1'b0);
    run_op("xnor",     5'd7,  32'h1234_5678, 32'h1234_5678, 5'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    run_op("pass",     5'd8,  32'hDEAD_BEEF, 32'h0,         5'd5, 1'b1, 1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    run_op("sra",      5'd12, 32'h8000_0000, 32'h0,         5'd4, 1'b0, 1, 32'hF800_0000, 32'h0, 1'b0, 1'b0);
    run_op("sll",      5'd10, 32'h8000_0001, 32'h0,         5'd1, 1'b0, 1, 32'h0000_0002, 32'h0, 1'b1, 1'b0);
    run_op("srl",      5'd14, 32'h0000_0003, 32'h0,         5'd1, 1'b0, 1, 32'h0000_0001, 32'h0, 1'b1, 1'b0);
    run_op("sll_sh0",  5'd10, 32'h8000_0001, 32'h0,         5'd0, 1'b0, 1, 32'h8000_0001, 32'h0, 1'b0, 1'b0);

    // multiply / divide
    run_op("mul",      5'd17, 32'hFFFF_FFFE, 32'h3,         5'd0, 1'b0, 33, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mulu",     5'd16, 32'hFFFF_FFFE, 32'h3,         5'd0, 1'b0, 33, 32'hFFFF_FFFA, 32'h0000_0002, 1'b0, 1'b0);
    run_op("mul_big",  5'd17, 32'h0001_0000, 32'h0001_0000, 5'd0, 1'b0, 33, 32'h0,         32'h1,         1'b0, 1'b0);
    run_op("div_neg",  5'd19, 32'hFFFF_FFF9, 32'h2,         5'd0, 1'b0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_negb", 5'd19, 32'h7,         32'hFFFF_FFFE, 5'd0, 1'b0, 33, 32'hFFFF_FFFD, 32'h1,         1'b0, 1'b0);
    run_op("divu",     5'd18, 32'd100,       32'd7,         5'd0, 1'b0, 33, 32'd14,        32'd2,         1'b0, 1'b0);
    run_op("divu_dz",  5'd18, 32'h7,         32'h0,         5'd0, 1'b0, 1,  32'hFFFF_FFFF, 32'h7,         1'b0, 1'b1);
    run_op("div_dz",   5'd19, 32'hFFFF_FFF0, 32'h0,         5'd0, 1'b0, 1,  32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0, 1'b1);
    run_op("div_ovf",  5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, 33, 32'h8000_0000, 32'h0,         1'b0, 1'b0);

    // backpressure: result held, new op waits, then accepted as result leaves
    op = 5'd19; a = 32'd100; b = 32'd7; shamt = '0; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 64'(lat), 64'd33);
    check("bp y",  64'(y),  64'd14);
    check("bp hi", 64'(hi), 64'd2);
    op = 5'd0; a = 32'd1; b = 32'd2; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold valid",    64'(out_valid), 64'd1);
      check("bp hold in_ready", 64'(in_ready),  64'd0);
      check("bp hold y",        64'(y),         64'd14);
      check("bp hold hi",       64'(hi),        64'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready up", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next valid", 64'(out_valid), 64'd1);
    check("bp next y",     64'(y),         64'd3);
    check("bp next hi",    64'(hi),        64'd0);
    @(posedge clk); #1;
    check("bp drained", 64'(out_valid), 64'd0);

    // flush in the middle of CALC
    op = 5'd17; a = 32'd5; b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("fl state calc", 64'(dbg_state), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl out_valid", 64'(out_valid), 64'd0);
    check("fl in_ready",  64'(in_ready),  64'd1);
    check("fl state",     64'(dbg_state), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw = saw | out_valid;
    end
    check("fl no result", 64'(saw), 64'd0);
    check("fl y kept",    64'(y),   64'd3);

    // reset during a multiply
    op = 5'd16; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs out_valid", 64'(out_valid), 64'd0);
    check("rs in_ready",  64'(in_ready),  64'd1);
    check("rs y",         64'(y),         64'd0);
    check("rs zero",      64'(zero),      64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw = saw | out_valid;
    end
    check("rs no result", 64'(saw),      64'd0);
    check("rs in_ready2", 64'(in_ready), 64'd1);

    run_op("recover", 5'd0, 32'd40, 32'd2, 5'd0, 1'b0, 1, 32'd42, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
